xgmii64_tx_enc: RTL and testbench

- Transmit-side XGMII 64-bit encoder: the egress counterpart of the 64-bit XGMII receive interface.
- Accepts a valid/ready byte stream holding frame content from DA through FCS.
- Drives txc/txd with start+preamble/SFD, data, terminate, idle and error characters, and enforces the minimum inter-packet gap.
- Sits between the MAC transmit datapath and the XGMII TX interface.

---
 rtl/xgmii64_tx_enc.sv | 234 +++++++++++++++++++++++
 tb/tb_xgmii64_tx_enc.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii64_tx_enc.sv
// ---------------------------------------------------------------------------
// xgmii64_tx_enc
// Transmit-side 64-bit XGMII encoder. Takes a valid/ready beat stream carrying
// frame bytes (DA..FCS) from the MAC TX datapath and produces the XGMII
// txc/txd word stream. It inserts start+preamble/SFD, passes data through,
// places terminate, pads with idles, flags mid-frame underrun with error
// characters and holds off the next start until the minimum inter-packet gap
// has elapsed.
//
// Ports
//   clk          TX clock, rising edge
//   reset        synchronous, active-low
//   in_valid     input beat valid
//   in_ready     beat accepted when in_valid & in_ready (combinational)
//   in_data      frame bytes, byte k = in_data[8k+7:8k], lane 0 first
//   in_keep      valid-byte mask, looked at only on the eop beat
//   in_sop       first beat of frame
//   in_eop       last beat of frame
//   txc          XGMII control flags, lane k = txc[k] (registered)
//   txd          XGMII data, lane k = txd[8k+7:8k] (registered)
//   underrun_err one-cycle pulse, aligned with the error word
//   tx_frame_cnt frames terminated cleanly (wraps)
//   tx_err_cnt   aborted frames plus stray beats (wraps)
//
// state | meaning
// IDLE  | idle words, counting gap bytes, waiting for a sop beat
// PRE   | emit S + preamble + SFD word
// DATA  | pass beats through; terminate on eop or abort on underrun
// TERM  | emit a stand-alone T word after a full eop beat
// ABORT | emit idles and discard the rest of an underrun frame
// IPG   | emit idles until the minimum gap is met
// ---------------------------------------------------------------------------
module xgmii64_tx_enc #(
  parameter int IPG_BYTES = 12,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [7:0]       in_keep,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic [7:0]       txc,
  output logic [63:0]      txd,
  output logic             underrun_err,
  output logic [CNT_W-1:0] tx_frame_cnt,
  output logic [CNT_W-1:0] tx_err_cnt
);

  localparam logic [7:0]  CH_I      = 8'h07;
  localparam logic [7:0]  CH_T      = 8'hFD;
  localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
  localparam logic [63:0] PRE_WORD  = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_WORD  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TERM_WORD = 64'h07070707070707FD;
  localparam logic [7:0]  IPG_MIN   = 8'(IPG_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_TERM,
    S_ABORT,
    S_IPG
  } state_t;

  state_t           r_state;
  logic [7:0]       r_idle_cnt;
  logic [7:0]       r_txc;
  logic [63:0]      r_txd;
  logic             r_underrun;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  state_t           w_state_nxt;
  logic [7:0]       w_idle_nxt;
  logic [7:0]       w_idle_inc;
  logic [7:0]       w_txc_nxt;
  logic [63:0]      w_txd_nxt;
  logic             w_ready;
  logic             w_underrun_nxt;
  logic             w_frame_inc;
  logic             w_err_inc;
  logic [3:0]       w_term_lane;
  logic [7:0]       w_term_txc;
  logic [63:0]      w_term_txd;

  // Gap byte counter advances one word (8 bytes) at a time and saturates so
  // a long idle period cannot wrap it back below the gap threshold.
  assign w_idle_inc = (r_idle_cnt > 8'd247) ? 8'd255 : (r_idle_cnt + 8'd8);

  // Terminate lane = lowest cleared keep bit; anything above it is ignored.
  // Scanning from the top down lets the lowest zero win.
  always_comb begin
    w_term_lane = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (!in_keep[k]) w_term_lane = 4'(k);
    end
  end

  // Partial terminate word: data below the T lane, T, then idles.
  always_comb begin
    w_term_txc = '0;
    w_term_txd = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(w_term_lane)) begin
        w_term_txc[k]        = 1'b0;
        w_term_txd[8*k +: 8] = in_data[8*k +: 8];
      end else if (k == int'(w_term_lane)) begin
        w_term_txc[k]        = 1'b1;
        w_term_txd[8*k +: 8] = CH_T;
      end else begin
        w_term_txc[k]        = 1'b1;
        w_term_txd[8*k +: 8] = CH_I;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_nxt     = r_idle_cnt;
    w_txc_nxt      = 8'hFF;
    w_txd_nxt      = IDLE_WORD;
    w_ready        = 1'b0;
    w_underrun_nxt = 1'b0;
    w_frame_inc    = 1'b0;
    w_err_inc      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_idle_nxt = w_idle_inc;
        if (in_valid && !in_sop) begin
          // Stray beat outside a frame: swallow it and count it.
          w_ready   = 1'b1;
          w_err_inc = 1'b1;
        end else if (in_valid && in_sop && (r_idle_cnt >= IPG_MIN)) begin
          // The sop beat stays on the bus; DATA consumes it after PRE.
          w_state_nxt = S_PRE;
        end
      end

      S_PRE: begin
        w_txc_nxt   = 8'h01;
        w_txd_nxt   = PRE_WORD;
        w_state_nxt = S_DATA;
      end

      S_DATA: begin
        w_ready = 1'b1;
        if (!in_valid) begin
          w_txc_nxt      = 8'hFF;
          w_txd_nxt      = ERR_WORD;
          w_underrun_nxt = 1'b1;
          w_err_inc      = 1'b1;
          w_state_nxt    = S_ABORT;
        end else if (!in_eop || (w_term_lane == 4'd8)) begin
          w_txc_nxt = 8'h00;
          w_txd_nxt = in_data;
          if (in_eop) w_state_nxt = S_TERM;
        end else begin
          w_txc_nxt   = w_term_txc;
          w_txd_nxt   = w_term_txd;
          // Idle lanes already sent inside the terminate word count toward
          // the gap.
          w_idle_nxt  = 8'd7 - {4'd0, w_term_lane};
          w_frame_inc = 1'b1;
          w_state_nxt = S_IPG;
        end
      end

      S_TERM: begin
        w_txc_nxt   = 8'hFF;
        w_txd_nxt   = TERM_WORD;
        w_idle_nxt  = 8'd7;
        w_frame_inc = 1'b1;
        w_state_nxt = S_IPG;
      end

      S_ABORT: begin
        w_ready = 1'b1;
        if (in_valid && in_eop) begin
          w_idle_nxt  = 8'd0;
          w_state_nxt = S_IPG;
        end
      end

      S_IPG: begin
        w_idle_nxt = w_idle_inc;
        // Leaving straight for PRE when a sop is already waiting saves the
        // extra idle word a pass through IDLE would cost.
        if (w_idle_inc >= IPG_MIN) begin
          if (in_valid && in_sop) w_state_nxt = S_PRE;
          else                    w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // No beat is ever accepted while reset is held.
  assign in_ready = reset & w_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idle_cnt  <= IPG_MIN;
      r_txc       <= 8'hFF;
      r_txd       <= IDLE_WORD;
      r_underrun  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_txc      <= w_txc_nxt;
      r_txd      <= w_txd_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_err_inc)   r_err_cnt   <= r_err_cnt + CNT_W'(1);
    end
  end

  assign txc          = r_txc;
  assign txd          = r_txd;
  assign underrun_err = r_underrun;
  assign tx_frame_cnt = r_frame_cnt;
  assign tx_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_xgmii64_tx_enc.sv
// Bench for xgmii64_tx_enc. Expected XGMII words come from a character-stream
// model (S/preamble, frame bytes, T, idle pad, gap words) or from constant
// tables; the DUT is never read back to form an expectation.
module tb_xgmii64_tx_enc;

  localparam logic [63:0] IW = 64'h0707070707070707;
  localparam logic [63:0] SW = 64'hD5555555555555FB;
  localparam logic [63:0] EW = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TW = 64'h07070707070707FD;
  localparam logic [63:0] TD = 64'h8877665544332211;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } word_t;

  typedef struct {
    logic [7:0]  keep;
    bit          full;
    logic [7:0]  exp_txc;
    logic [63:0] exp_txd;
    int          gap;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic [7:0]  txc;
  logic [63:0] txd;
  logic        underrun_err;
  logic [31:0] tx_frame_cnt, tx_err_cnt;

  logic        b_rst;
  logic        b_in_ready;
  logic [7:0]  b_txc;
  logic [63:0] b_txd;
  logic        b_underrun;
  logic [31:0] b_frame_cnt, b_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src_q[$];
  word_t exp_q[$];

  xgmii64_tx_enc #(.IPG_BYTES(12), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_sop(in_sop), .in_eop(in_eop),
    .txc(txc), .txd(txd), .underrun_err(underrun_err),
    .tx_frame_cnt(tx_frame_cnt), .tx_err_cnt(tx_err_cnt)
  );

  // Second instance with a wider gap, fed a constant stream of 1-beat frames.
  xgmii64_tx_enc #(.IPG_BYTES(24), .CNT_W(32)) dut_b (
    .clk(clk), .reset(b_rst),
    .in_valid(1'b1), .in_ready(b_in_ready), .in_data(TD),
    .in_keep(8'hFF), .in_sop(1'b1), .in_eop(1'b1),
    .txc(b_txc), .txd(b_txd), .underrun_err(b_underrun),
    .tx_frame_cnt(b_frame_cnt), .tx_err_cnt(b_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input word_t got, input word_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got txc=%h txd=%h, want txc=%h txd=%h",
               nm, got.c, got.d, want.c, want.d);
    end
  endtask

  function automatic word_t mk(input logic [7:0] c, input logic [63:0] d);
    word_t w;
    w.c = c;
    w.d = d;
    return w;
  endfunction

  // Model: a frame of len random bytes becomes the character stream
  // S,55x6,D5,<bytes>,T padded with I to a word boundary, followed by the
  // fewest idle words that bring the trailing idle byte count to ipg.
  task automatic add_frame(input int len, input int ipg);
    logic [7:0] fb[$];
    bit         cc[$];
    logic [7:0] cv[$];
    beat_t      bt;
    word_t      wd;
    int         nb, k, t, w;
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    nb = (len + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      bt.data = {$urandom, $urandom};
      bt.keep = 8'h00;
      bt.sop  = (j == 0);
      bt.eop  = (j == nb - 1);
      for (int l = 0; l < 8; l++) begin
        if (8*j + l < len) begin
          bt.data[8*l +: 8] = fb[8*j + l];
          bt.keep[l]        = 1'b1;
        end
      end
      k = len - 8*j;
      if (bt.eop && k < 8) bt.keep = bt.keep | (8'($urandom) & (8'hFF << (k + 1)));
      src_q.push_back(bt);
    end
    cc.push_back(1'b1); cv.push_back(8'hFB);
    for (int i = 0; i < 6; i++) begin cc.push_back(1'b0); cv.push_back(8'h55); end
    cc.push_back(1'b0); cv.push_back(8'hD5);
    foreach (fb[i]) begin cc.push_back(1'b0); cv.push_back(fb[i]); end
    cc.push_back(1'b1); cv.push_back(8'hFD);
    t = 0;
    while (cc.size() % 8 != 0) begin cc.push_back(1'b1); cv.push_back(8'h07); t++; end
    for (int j = 0; j < cc.size() / 8; j++) begin
      for (int l = 0; l < 8; l++) begin
        wd.c[l]         = cc[8*j + l];
        wd.d[8*l +: 8]  = cv[8*j + l];
      end
      exp_q.push_back(wd);
    end
    w = 0;
    while (t + 8*w < ipg) w++;
    for (int i = 0; i < w; i++) exp_q.push_back(mk(8'hFF, IW));
  endtask

  // Stream src_q into the DUT and compare output words against exp_q,
  // starting at the first non-idle word. pre_idle = idle words seen first.
  task automatic run_stream(output int pre_idle);
    bit    started, acc;
    int    budget;
    word_t w;
    started  = 0;
    budget   = 0;
    pre_idle = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0].data;
        in_keep  = src_q[0].keep;
        in_sop   = src_q[0].sop;
        in_eop   = src_q[0].eop;
      end else begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      #1 acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) void'(src_q.pop_front());
      if (!started && txc == 8'hFF && txd == IW) begin
        pre_idle++;
      end else begin
        started = 1;
        w = exp_q.pop_front();
        chk_word("stream_word", mk(txc, txd), w);
      end
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: %0d words still expected", exp_q.size());
    end
    exp_q.delete();
    src_q.delete();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic push_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic s, input logic e);
    bit acc;
    acc      = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_sop = s; in_eop = e;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 acc = in_ready;
      @(negedge clk);
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL push_beat_timeout: beat not accepted, want accept");
    end
  endtask

  vec_t        tv[8];
  int          pi;
  logic [31:0] frm0, err0;
  word_t       bexp[$];
  bit          found;

  initial begin
    tv[0] = '{8'hFF, 1'b1, 8'hFF, 64'h07070707070707FD, 1};
    tv[1] = '{8'h0F, 1'b0, 8'hF0, 64'h070707FD44332211, 2};
    tv[2] = '{8'h00, 1'b0, 8'hFF, 64'h07070707070707FD, 1};
    tv[3] = '{8'h01, 1'b0, 8'hFE, 64'h070707070707FD11, 1};
    tv[4] = '{8'h7F, 1'b0, 8'h80, 64'hFD77665544332211, 2};
    tv[5] = '{8'h0B, 1'b0, 8'hFC, 64'h0707070707FD2211, 1};
    tv[6] = '{8'h3F, 1'b0, 8'hC0, 64'h07FD665544332211, 2};
    tv[7] = '{8'hF7, 1'b0, 8'hF8, 64'h07070707FD332211, 1};

    reset = 1'b0; b_rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_keep = '0;

    // Reset state.
    repeat (3) begin
      @(negedge clk);
      chk("rst_txc", 64'(txc), 64'hFF);
      chk("rst_txd", txd, IW);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_underrun", 64'(underrun_err), 64'd0);
      chk("rst_frame_cnt", 64'(tx_frame_cnt), 64'd0);
      chk("rst_err_cnt", 64'(tx_err_cnt), 64'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_txc", 64'(txc), 64'hFF);
      chk("idle_txd", txd, IW);
      chk("idle_ready", 64'(in_ready), 64'd0);
    end

    // Stray beat in IDLE.
    err0 = tx_err_cnt;
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = TD; in_keep = 8'hFF;
    #1 chk("stray_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stray_txd", txd, IW);
    chk("stray_txc", 64'(txc), 64'hFF);
    chk("stray_err_cnt", 64'(tx_err_cnt), 64'(err0 + 32'd1));

    // Terminate-lane table: single-beat frames, back to back.
    frm0 = tx_frame_cnt;
    for (int i = 0; i < 8; i++) begin
      src_q.push_back('{TD, tv[i].keep, 1'b1, 1'b1});
      exp_q.push_back(mk(8'h01, SW));
      if (tv[i].full) exp_q.push_back(mk(8'h00, TD));
      exp_q.push_back(mk(tv[i].exp_txc, tv[i].exp_txd));
      for (int g = 0; g < tv[i].gap; g++) exp_q.push_back(mk(8'hFF, IW));
    end
    run_stream(pi);
    chk("table_pre_idle", 64'(pi), 64'd1);
    chk("table_frame_cnt", 64'(tx_frame_cnt), 64'(frm0 + 32'd8));

    // Two 64-byte frames back to back.
    frm0 = tx_frame_cnt;
    add_frame(64, 12);
    add_frame(64, 12);
    run_stream(pi);
    chk("b2b64_frame_cnt", 64'(tx_frame_cnt), 64'(frm0 + 32'd2));

    // Two 60-byte frames (terminate in lane 4, two idle words between).
    frm0 = tx_frame_cnt;
    add_frame(60, 12);
    add_frame(60, 12);
    run_stream(pi);
    chk("f60_frame_cnt", 64'(tx_frame_cnt), 64'(frm0 + 32'd2));

    // Random frame lengths with junk keep bits above the first zero.
    frm0 = tx_frame_cnt;
    err0 = tx_err_cnt;
    for (int i = 0; i < 12; i++) add_frame(int'($urandom_range(1, 48)), 12);
    run_stream(pi);
    chk("rand_frame_cnt", 64'(tx_frame_cnt), 64'(frm0 + 32'd12));
    chk("rand_err_cnt", 64'(tx_err_cnt), 64'(err0));

    // Underrun after three beats of a ten-beat frame.
    frm0 = tx_frame_cnt;
    err0 = tx_err_cnt;
    push_beat(64'h0101010101010101, 8'hFF, 1'b1, 1'b0);
    push_beat(64'h0202020202020202, 8'hFF, 1'b0, 1'b0);
    push_beat(64'h0303030303030303, 8'hFF, 1'b0, 1'b0);
    chk_word("ur_last_data", mk(txc, txd), mk(8'h00, 64'h0303030303030303));
    in_valid = 1'b0;
    @(negedge clk);
    chk_word("ur_err_word", mk(txc, txd), mk(8'hFF, EW));
    chk("ur_pulse", 64'(underrun_err), 64'd1);
    chk("ur_err_cnt", 64'(tx_err_cnt), 64'(err0 + 32'd1));
    @(negedge clk);
    chk("ur_pulse_end", 64'(underrun_err), 64'd0);
    chk_word("ur_abort_idle", mk(txc, txd), mk(8'hFF, IW));
    for (int b = 3; b < 10; b++) begin
      push_beat({8{8'(b + 1)}}, 8'hFF, 1'b0, (b == 9));
      chk_word("ur_drain_idle", mk(txc, txd), mk(8'hFF, IW));
    end
    chk("ur_frame_cnt", 64'(tx_frame_cnt), 64'(frm0));
    add_frame(16, 12);
    run_stream(pi);
    chk("ur_gap_words", 64'(pi), 64'd2);
    chk("ur_next_frame_cnt", 64'(tx_frame_cnt), 64'(frm0 + 32'd1));
    chk("ur_err_cnt_final", 64'(tx_err_cnt), 64'(err0 + 32'd1));

    // IPG_BYTES=24: T word then three idle words before the next S.
    for (int f = 0; f < 2; f++) begin
      bexp.push_back(mk(8'h01, SW));
      bexp.push_back(mk(8'h00, TD));
      bexp.push_back(mk(8'hFF, TW));
      for (int g = 0; g < 3; g++) bexp.push_back(mk(8'hFF, IW));
    end
    b_rst = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (!(b_txc == 8'hFF && b_txd == IW)) found = 1;
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL ipg24_start: no S word seen, want S within 40 cycles");
    end else begin
      foreach (bexp[i]) begin
        if (i > 0) @(negedge clk);
        chk_word("ipg24_word", mk(b_txc, b_txd), bexp[i]);
      end
    end

    // Reset asserted in DATA.
    push_beat(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b1, 1'b0);
    push_beat(64'hBBBBBBBBBBBBBBBB, 8'hFF, 1'b0, 1'b0);
    push_beat(64'hCCCCCCCCCCCCCCCC, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    chk_word("mid_rst_word", mk(txc, txd), mk(8'hFF, IW));
    chk("mid_rst_frame_cnt", 64'(tx_frame_cnt), 64'd0);
    chk("mid_rst_err_cnt", 64'(tx_err_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_underrun", 64'(underrun_err), 64'd0);
    reset = 1'b1;
    add_frame(20, 12);
    run_stream(pi);
    chk("post_rst_pre_idle", 64'(pi), 64'd1);
    chk("post_rst_frame_cnt", 64'(tx_frame_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
